// File: rtl/wr_result_sink_pkg.sv
// Shared definitions for the write-result sink: result word width and frame-state encodings.
// The accelerator wrapper and the benches use the same values.
package wr_result_sink_pkg;

    localparam int RESULT_W = 21;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } frame_state_e;

    // Next value of a frame word counter that stops at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        if (value == 8'hFF) begin
            return value;
        end else begin
            return value + 8'd1;
        end
    endfunction

endpackage

// File: rtl/wr_result_sink_sync_fifo.sv
// Single-clock FIFO with a registered pop port and registered occupancy flags.
// Push and pop are assumed to be already qualified by the caller.
module sync_fifo #(
    parameter int DATA_W = 21,
    parameter int DEPTH  = 8,
    parameter int AW     = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              pop_valid,
    output logic [AW:0]       count,
    output logic              full,
    output logic              empty
);

    localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]     wptr_r;
    logic [AW-1:0]     rptr_r;
    logic [AW:0]       count_r;
    logic [AW:0]       count_nxt_s;
    logic              full_r;
    logic              empty_r;
    logic [DATA_W-1:0] pop_data_r;
    logic              pop_valid_r;

    // Occupancy after this cycle's push/pop; a simultaneous push and pop leave it unchanged.
    always_comb begin
        count_nxt_s = count_r;
        case ({push, pop})
            2'b10:   count_nxt_s = count_r + {{AW{1'b0}}, 1'b1};
            2'b01:   count_nxt_s = count_r - {{AW{1'b0}}, 1'b1};
            default: count_nxt_s = count_r;
        endcase
    end

    // Storage array; contents need no reset because the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[wptr_r] <= push_data;
        end
    end

    // Pointers, flags and the registered pop port.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr_r      <= {AW{1'b0}};
            rptr_r      <= {AW{1'b0}};
            count_r     <= {(AW+1){1'b0}};
            full_r      <= 1'b0;
            empty_r     <= 1'b1;
            pop_data_r  <= {DATA_W{1'b0}};
            pop_valid_r <= 1'b0;
        end else begin
            count_r     <= count_nxt_s;
            full_r      <= (count_nxt_s == FULL_C);
            empty_r     <= (count_nxt_s == {(AW+1){1'b0}});
            pop_valid_r <= pop;
            if (push) begin
                wptr_r <= wptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            if (pop) begin
                // Reads the pre-write entry even when wptr == rptr at full.
                pop_data_r <= mem_r[rptr_r];
                rptr_r     <= rptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
        end
    end

    assign pop_data  = pop_data_r;
    assign pop_valid = pop_valid_r;
    assign count     = count_r;
    assign full      = full_r;
    assign empty     = empty_r;

endmodule

// File: rtl/wr_result_sink.sv
// Receiving end of the accelerator write-result stream: buffers every word that fits,
// never stalls the writer, and tracks per-frame word count, completion and drops.
module wr_result_sink
    import wr_result_sink_pkg::*;
#(
    parameter int DATA_W = RESULT_W,
    parameter int DEPTH  = 8,
    parameter int AW     = 3,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              done,
    input  logic              wr_req,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_req,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [AW:0]       count,
    output logic              empty,
    output logic              full,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic              frame_done,
    output logic              overflow
);

    frame_state_e     state_r;
    logic [CNT_W-1:0] frame_cnt_r;
    logic [CNT_W-1:0] cnt_base_s;
    logic             frame_done_r;
    logic             overflow_r;
    logic             overflow_base_s;
    logic             rd_acc_s;
    logic             wr_acc_s;
    logic             full_s;
    logic             empty_s;

    // A read frees a slot in the same cycle, so a full FIFO still takes a concurrent write.
    always_comb begin
        rd_acc_s = rd_req & ~empty_s;
        wr_acc_s = wr_req & (~full_s | rd_acc_s);
    end

    // start clears the frame status first; this cycle's write is then counted on top.
    always_comb begin
        if (start) begin
            cnt_base_s      = {CNT_W{1'b0}};
            overflow_base_s = 1'b0;
        end else begin
            cnt_base_s      = frame_cnt_r;
            overflow_base_s = overflow_r;
        end
    end

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_acc_s),
        .push_data (wr_data),
        .pop       (rd_acc_s),
        .pop_data  (rd_data),
        .pop_valid (rd_valid),
        .count     (count),
        .full      (full_s),
        .empty     (empty_s)
    );

    // Frame state machine with its counter and sticky status flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            frame_cnt_r  <= {CNT_W{1'b0}};
            frame_done_r <= 1'b0;
            overflow_r   <= 1'b0;
        end else begin
            if (wr_acc_s && (cnt_base_s != {CNT_W{1'b1}})) begin
                frame_cnt_r <= cnt_base_s + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                frame_cnt_r <= cnt_base_s;
            end
            overflow_r <= overflow_base_s | (wr_req & ~wr_acc_s);

            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r      <= ST_RUN;
                        frame_done_r <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (start) begin
                        frame_done_r <= 1'b0;
                    end else if (done) begin
                        state_r      <= ST_DONE;
                        frame_done_r <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        state_r      <= ST_RUN;
                        frame_done_r <= 1'b0;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    frame_done_r <= 1'b0;
                end
            endcase
        end
    end

    assign full       = full_s;
    assign empty      = empty_s;
    assign frame_cnt  = frame_cnt_r;
    assign frame_done = frame_done_r;
    assign overflow   = overflow_r;

endmodule

// File: tb/tb_wr_result_sink.sv
// Directed self-checking bench for wr_result_sink with hand-computed expectations.
module tb_wr_result_sink;
    import wr_result_sink_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        done = 1'b0;
    logic        wr_req = 1'b0;
    logic [20:0] wr_data = 21'd0;
    logic        rd_req = 1'b0;
    logic [20:0] rd_data;
    logic        rd_valid;
    logic [3:0]  count;
    logic        empty;
    logic        full;
    logic [7:0]  frame_cnt;
    logic        frame_done;
    logic        overflow;

    int total = 0;
    int bad = 0;

    wr_result_sink dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .done       (done),
        .wr_req     (wr_req),
        .wr_data    (wr_data),
        .rd_req     (rd_req),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .count      (count),
        .empty      (empty),
        .full       (full),
        .frame_cnt  (frame_cnt),
        .frame_done (frame_done),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        tick();
        tick();
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        rst = 1'b1;

        // Three writes, then three reads in order.
        wr_req = 1'b1;
        wr_data = 21'h00001; tick();
        check("w1_count", 32'(count), 32'd1);
        check("w1_empty", 32'(empty), 32'd0);
        wr_data = 21'h00002; tick();
        wr_data = 21'h1FFFFF; tick();
        wr_req = 1'b0;
        check("w3_count", 32'(count), 32'd3);
        check("w3_frame_cnt", 32'(frame_cnt), 32'd3);
        rd_req = 1'b1;
        tick();
        check("r1_valid", 32'(rd_valid), 32'd1);
        check("r1_data", 32'(rd_data), 32'h00001);
        tick();
        check("r2_valid", 32'(rd_valid), 32'd1);
        check("r2_data", 32'(rd_data), 32'h00002);
        tick();
        check("r3_valid", 32'(rd_valid), 32'd1);
        check("r3_data", 32'(rd_data), 32'h1FFFFF);
        check("r3_empty", 32'(empty), 32'd1);

        // Read while empty is ignored.
        tick();
        check("re_valid", 32'(rd_valid), 32'd0);
        check("re_data", 32'(rd_data), 32'h1FFFFF);
        check("re_count", 32'(count), 32'd0);
        rd_req = 1'b0;

        // New frame, ten writes into an 8-deep FIFO.
        start = 1'b1; tick(); start = 1'b0;
        check("st_frame_cnt", 32'(frame_cnt), 32'd0);
        wr_req = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            wr_data = 21'(32'h100 + i);
            tick();
            if (i == 7) check("w7_full", 32'(full), 32'd0);
            if (i == 8) begin
                check("w8_full", 32'(full), 32'd1);
                check("w8_count", 32'(count), 32'd8);
                check("w8_overflow", 32'(overflow), 32'd0);
            end
        end
        wr_req = 1'b0;
        check("w10_overflow", 32'(overflow), 32'd1);
        check("w10_frame_cnt", 32'(frame_cnt), 32'd8);
        check("w10_count", 32'(count), 32'd8);

        // Clear the sticky flag, then write and read together at full.
        start = 1'b1; tick(); start = 1'b0;
        check("st2_overflow", 32'(overflow), 32'd0);
        check("st2_count", 32'(count), 32'd8);
        wr_req = 1'b1; rd_req = 1'b1; wr_data = 21'h002AA;
        tick();
        wr_req = 1'b0;
        check("fs_valid", 32'(rd_valid), 32'd1);
        check("fs_data", 32'(rd_data), 32'h101);
        check("fs_count", 32'(count), 32'd8);
        check("fs_overflow", 32'(overflow), 32'd0);
        check("fs_frame_cnt", 32'(frame_cnt), 32'd1);
        for (int i = 2; i <= 8; i++) begin
            tick();
            check("drain_data", 32'(rd_data), 32'h100 + 32'(i));
        end
        tick();
        check("drain_last", 32'(rd_data), 32'h2AA);
        check("drain_empty", 32'(empty), 32'd1);
        tick();
        check("drain_idle_valid", 32'(rd_valid), 32'd0);
        rd_req = 1'b0;

        // Frame with start, four writes, done; a second start keeps the FIFO.
        start = 1'b1; tick(); start = 1'b0;
        wr_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_data = 21'(32'h11 + i);
            tick();
        end
        wr_req = 1'b0;
        done = 1'b1; tick(); done = 1'b0;
        check("fd_frame_done", 32'(frame_done), 32'd1);
        check("fd_frame_cnt", 32'(frame_cnt), 32'd4);
        check("fd_state", 32'(dut.state_r), 32'(ST_DONE));
        start = 1'b1; tick(); start = 1'b0;
        check("st3_frame_done", 32'(frame_done), 32'd0);
        check("st3_frame_cnt", 32'(frame_cnt), 32'd0);
        check("st3_count", 32'(count), 32'd4);
        check("st3_state", 32'(dut.state_r), 32'(ST_RUN));

        // A write in a start cycle counts after the clear.
        start = 1'b1; wr_req = 1'b1; wr_data = 21'h00055;
        tick();
        start = 1'b0;
        check("sw_frame_cnt", 32'(frame_cnt), 32'd1);
        check("sw_count", 32'(count), 32'd5);

        // Sustained write+read saturates the frame counter.
        rd_req = 1'b1;
        for (int i = 0; i < 260; i++) begin
            wr_data = 21'(i);
            tick();
        end
        wr_req = 1'b0; rd_req = 1'b0;
        check("sat_frame_cnt", 32'(frame_cnt), 32'hFF);
        check("sat_count", 32'(count), 32'd5);
        check("sat_overflow", 32'(overflow), 32'd0);

        // Mid-frame reset with five words stored.
        rst = 1'b0; tick(); rst = 1'b1;
        check("mr_count", 32'(count), 32'd0);
        check("mr_empty", 32'(empty), 32'd1);
        check("mr_state", 32'(dut.state_r), 32'(ST_IDLE));
        check("mr_frame_cnt", 32'(frame_cnt), 32'd0);
        check("mr_frame_done", 32'(frame_done), 32'd0);
        check("mr_overflow", 32'(overflow), 32'd0);
        check("mr_rd_data", 32'(rd_data), 32'd0);
        rd_req = 1'b1; tick(); rd_req = 1'b0;
        check("mr_read_valid", 32'(rd_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wr_result_sink.md
# wr_result_sink

Receiving end of the accelerator write-result stream. Captures every `wr_req`/`wr_data` word issued by the accelerator wrapper into an on-chip FIFO, tracks per-run frame status (word count, completion, overflow), and offers a registered read port to the downstream consumer (host bench, display logic or next stage). The accelerator has no back-pressure input, so this block must never stall the writer. Words that cannot be stored are dropped and flagged.

## Interface
Parameters:
- `DATA_W`, 21: result word width; matches accelerator `wr_data`.
- `DEPTH`, 8: FIFO entries; power of two, at least 2.
- `AW`, 3: log2(`DEPTH`).
- `CNT_W`, 8: frame word counter width.

Ports:
- `clk`, in, 1: single clock; all logic on the rising edge.
- `rst`, in, 1: synchronous, active-low reset (`rst`=0 resets on the next `clk` edge).
- `start`, in, 1: accelerator start; the same signal that drives the wrapper. Opens a new frame.
- `done`, in, 1: accelerator done pulse; closes the frame.
- `wr_req`, in, 1: write strobe. One word per high cycle.
- `wr_data`, in, `DATA_W`: result word, valid when `wr_req`=1.
- `rd_req`, in, 1: consumer requests one word.
- `rd_data`, out, `DATA_W`: registered read word.
- `rd_valid`, out, 1: one-cycle pulse marking `rd_data` valid.
- `count`, out, `AW`+1: current FIFO occupancy.
- `empty`, out, 1: `count`==0.
- `full`, out, 1: `count`==`DEPTH`.
- `frame_cnt`, out, `CNT_W`: words accepted since the last `start`.
- `frame_done`, out, 1: sticky; set by `done`.
- `overflow`, out, 1: sticky; set when a word is dropped.

## Operation
- Reset (`rst`=0) drives every output to 0 except `empty`, which is 1. Pointers are cleared. FIFO contents are don't-care.
- Write acceptance: `wr_req`=1 and (`full`=0 or a read is accepted in the same cycle).
  - Accepted word is written at `wptr`, `wptr` increments modulo `DEPTH`, and `frame_cnt` increments, saturating at all-ones.
  - A rejected write is discarded, `overflow` is set, and `frame_cnt` does not change.
- Read acceptance: `rd_req`=1 and `empty`=0.
  - `rd_data` is loaded from `rptr` and `rptr` increments modulo `DEPTH`.
  - A read while empty is ignored: `rd_valid` stays 0 and `rd_data` holds its value.
- Simultaneous accepted read and write: `count` is unchanged. This is legal at both `full` and non-empty.
  - A write into an empty FIFO is not readable in the same cycle. There is no bypass.
- Frame state machine, states IDLE, RUN, DONE:
  - IDLE to RUN on `start`: clears `frame_cnt`, `frame_done` and `overflow`. FIFO contents are kept.
  - RUN to DONE on `done`: sets `frame_done`.
  - DONE to RUN on `start`, with the same clears as IDLE to RUN.
  - `start` asserted for several cycles re-clears each cycle. An accepted write in a `start` cycle still counts: the counter clears to 0, then adds 1.
  - `wr_req` accepted in IDLE or DONE is still stored and counted.
  - `done` and `wr_req` in the same cycle: the word is stored and `frame_done` is also set.
- `rst`=0 mid-frame aborts everything. The state returns to IDLE and stored words are lost.

## Timing
- Write latency: a word accepted at edge N is visible in `count`/`empty`/`full` after edge N and is readable from cycle N+1.
- Read latency: 1 cycle. `rd_req` sampled at edge N gives `rd_data`/`rd_valid` valid after edge N. `rd_valid` lasts one cycle per accepted read.
- Back-to-back `rd_req` gives one word per cycle until empty.
- Flags (`count`, `full`, `empty`, `frame_cnt`, `frame_done`, `overflow`) are all registered and update on the same edge as the event that changes them.
- Throughput: 1 write and 1 read per cycle, sustained.

## Structure
- Shared defines file: `RESULT_W` (21) and the frame-state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2). Both are shared with the accelerator wrapper and the benches.
- One sub-module, `sync_fifo`: parameterised `DATA_W`/`DEPTH`, with push/pop, registered pop data, and count/full/empty outputs.
- The top level holds the frame FSM, `frame_cnt`, the sticky flags and the accept logic.

## Test plan
- Reset, then 3 writes (0x00001, 0x00002, 0x1FFFFF) -> `count`=3, `frame_cnt`=3. Three `rd_req` cycles return the words in that order, each with `rd_valid` 1 cycle later. Afterwards `empty`=1.
- 10 consecutive writes with no reads (`DEPTH`=8) -> `full`=1 after the 8th. Writes 9 and 10 are dropped, `overflow`=1, `frame_cnt`=8, and the reads return only words 1–8.
- FIFO full with `wr_req` and `rd_req` in the same cycle -> the word is accepted, `count` stays 8, `overflow` stays 0.
- `rd_req` while empty -> `rd_valid`=0 and `rd_data` unchanged.
- `start` pulse, then 4 writes, then `done` -> `frame_done`=1 and `frame_cnt`=4. A second `start` -> `frame_done`=0 and `frame_cnt`=0, and the FIFO still holds the 4 words.
- `rst`=0 for 1 cycle mid-frame with 5 words stored -> `count`=0, `empty`=1, state IDLE, and all flags 0.
